// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master side requests divisions; the slave side is the divider itself.
interface seq_divider_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one shift/trial-subtract step per
// clock, N steps per operation, single operation in flight via start/done.
module seq_divider #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         resetn,
    seq_divider_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  r_q, r_d;        // partial remainder
    logic [N-1:0]  q_q, q_d;        // dividend shifting out / quotient shifting in
    logic [N-1:0]  d_q, d_d;        // latched divisor
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    r_shift;         // R' is one bit wider so the shift cannot overflow
    logic [N-1:0]  trial;
    logic          borrow;
    logic [N-1:0]  r_next;
    logic [N-1:0]  q_next;

    // One iteration: shift {R,Q} left and trial-subtract D through a ripple-borrow chain
    always_comb begin
        r_shift = {r_q, q_q[N-1]};
        trial   = '0;
        borrow  = 1'b0;
        for (int i = 0; i < N; i++) begin
            trial[i] = r_shift[i] ^ d_q[i] ^ borrow;
            borrow   = (~r_shift[i] & d_q[i]) | (~(r_shift[i] ^ d_q[i]) & borrow);
        end
        // Top stage subtracts a zero divisor bit from the extra R' bit.
        borrow = ~r_shift[N] & borrow;
        r_next = borrow ? r_shift[N-1:0] : trial;
        q_next = {q_q[N-2:0], ~borrow};
    end

    // Next-state and result computation for the IDLE/RUN/DONE controller
    always_comb begin
        // NOTE: every signal gets a hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        count_d = count_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            S_RUN: begin
                r_d     = r_next;
                q_d     = q_next;
                count_d = count_q + 1'b1;
                if (count_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                    quot_d  = q_next;
                    rem_d   = r_next;
                    dbz_d   = 1'b0;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
                state_d = S_IDLE;
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        d_d     = bus.divisor;
                        q_d     = bus.dividend;
                        r_d     = '0;
                        count_d = '0;
                    end
                end
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: all of these are plain registers (no RAM), so every one is cleared by reset.
        if (!resetn) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a transaction-level reference model
// (plain / and %) is compared against the DUT on every clock, plus directed
// literal checks and an exhaustive back-to-back operand sweep.
module tb_seq_divider;
    localparam int N = 4;

    logic clock;
    logic resetn;

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks only "cycles left until the result appears"
    // and computes results with ordinary integer division.
    int         m_left;
    logic       m_done;
    logic [3:0] m_q, m_r, p_q, p_r;
    logic       m_z;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_z    <= 1'b0;
            p_q    <= '0;
            p_r    <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_q    <= p_q;
                    m_r    <= p_r;
                    m_z    <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (bus.start) begin
                if (bus.divisor == 0) begin
                    m_q    <= 4'hF;
                    m_r    <= bus.dividend;
                    m_z    <= 1'b1;
                    m_done <= 1'b1;
                end else begin
                    p_q    <= bus.dividend / bus.divisor;
                    p_r    <= bus.dividend % bus.divisor;
                    m_left <= N;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (cmp_en && resetn) begin
            check("busy",        bus.busy,        (m_left > 0));
            check("done",        bus.done,        m_done);
            check("quotient",    bus.quotient,    m_q);
            check("remainder",   bus.remainder,   m_r);
            check("div_by_zero", bus.div_by_zero, m_z);
            check("busy_and_done", (bus.busy && bus.done), 0);
        end
    end

    // Single request with start pulsed for one cycle; checks latency, busy
    // length and the literal result, then that the result holds with done low.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er, input logic ez);
        int cyc;
        int busy_cnt;
        string tag;
        tag = $sformatf("%0d/%0d", a, b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        cyc = 0;
        busy_cnt = 0;
        do begin
            @(negedge clock);
            cyc++;
            bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
        end while (!bus.done && cyc < 20);
        check({tag, " latency"},   cyc,             (b == 0) ? 1 : 5);
        check({tag, " busy_len"},  busy_cnt,        (b == 0) ? 0 : 4);
        check({tag, " quotient"},  bus.quotient,    eq);
        check({tag, " remainder"}, bus.remainder,   er);
        check({tag, " dbz"},       bus.div_by_zero, ez);
        @(negedge clock);
        check({tag, " done_drop"}, bus.done,        0);
        check({tag, " q_hold"},    bus.quotient,    eq);
        check({tag, " r_hold"},    bus.remainder,   er);
    endtask

    initial begin
        int cyc;
        resetn       = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clock);
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst quotient", bus.quotient, 0);
        check("rst remainder", bus.remainder, 0);
        check("rst dbz", bus.div_by_zero, 0);
        resetn = 1'b1;
        cmp_en = 1'b1;

        // Directed operations with hand-computed results
        do_op(4'd13, 4'd3, 4'd4,  4'd1, 1'b0);
        do_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        do_op(4'd3,  4'd9, 4'd0,  4'd3, 1'b0);
        do_op(4'd0,  4'd5, 4'd0,  4'd0, 1'b0);
        do_op(4'd7,  4'd0, 4'd15, 4'd7, 1'b1);
        do_op(4'd8,  4'd2, 4'd4,  4'd0, 1'b0);

        // Start during RUN is ignored; start held through DONE chains the next op
        bus.start = 1'b1; bus.dividend = 4'd9; bus.divisor = 4'd2;
        @(negedge clock); bus.start = 1'b0;
        @(negedge clock); bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd7;
        @(negedge clock); bus.start = 1'b0;
        @(negedge clock); bus.start = 1'b1;
        @(negedge clock);
        check("ignore done", bus.done, 1);
        check("ignore quotient", bus.quotient, 4);
        check("ignore remainder", bus.remainder, 1);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
            bus.start = 1'b0;
        end while (!bus.done && cyc < 20);
        check("b2b latency", cyc, 5);
        check("b2b quotient", bus.quotient, 2);
        check("b2b remainder", bus.remainder, 0);
        @(negedge clock);

        // Asynchronous reset in the middle of RUN
        bus.start = 1'b1; bus.dividend = 4'd11; bus.divisor = 4'd3;
        @(negedge clock); bus.start = 1'b0;
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        check("async busy", bus.busy, 0);
        check("async done", bus.done, 0);
        check("async quotient", bus.quotient, 0);
        check("async remainder", bus.remainder, 0);
        check("async dbz", bus.div_by_zero, 0);
        repeat (6) begin
            @(negedge clock);
            check("reset no_done", bus.done, 0);
        end
        resetn = 1'b1;
        do_op(4'd11, 4'd3, 4'd3, 4'd2, 1'b0);

        // Exhaustive back-to-back sweep with start held high
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                bus.start    = 1'b1;
                bus.dividend = 4'(a);
                bus.divisor  = 4'(b);
                cyc = 0;
                do begin
                    @(negedge clock);
                    cyc++;
                end while (!bus.done && cyc < 20);
                check($sformatf("sweep %0d/%0d spacing", a, b), cyc, (b == 0) ? 1 : 5);
                check($sformatf("sweep %0d/%0d quotient", a, b), bus.quotient,
                      (b == 0) ? 15 : a / b);
                check($sformatf("sweep %0d/%0d remainder", a, b), bus.remainder,
                      (b == 0) ? a : a % b);
            end
        end
        bus.start = 1'b0;
        @(negedge clock);

        // Random traffic; the every-cycle compare does the checking
        for (int i = 0; i < 800; i++) begin
            bus.start    = 1'($urandom_range(0, 1));
            bus.dividend = 4'($urandom);
            bus.divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            @(negedge clock);
        end
        bus.start = 1'b0;
        repeat (8) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
